// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave word receiver.
//   state_t   : receive FSM state encoding
//   BUS_IDLE  : idle level of SCL/SDA (open-drain, pulled high)
//   len_clamp : maps a requested transfer length onto 1..max_len
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_HI = 3'd1,
        ST_HOLD_HI = 3'd2,
        ST_DONE    = 3'd3,
        ST_ABORT   = 3'd4
    } state_t;

    localparam logic BUS_IDLE = 1'b1;

    // Zero or an over-long request both mean "a full word".
    function automatic int unsigned len_clamp(input int unsigned len,
                                              input int unsigned max_len);
        int unsigned res;
        if ((len == 32'd0) || (len > max_len)) begin
            res = max_len;
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// Conditions one I2C pad line: 2-flop synchroniser, optional stability
// filter (I2C_SLAVE_READ_WORD_FILTER_EN), then edge detection.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   line_i     : raw pad level
//   level      : conditioned level, time-aligned with rise/fall
//   rise, fall : one-cycle pulses on conditioned edges
// Optional feature macro: I2C_SLAVE_READ_WORD_FILTER_EN (adds FILT_LEN
// clk of latency and rejects pulses shorter than FILT_LEN clk).
module i2c_line_cond
    import i2c_pkg::*;
`ifdef I2C_SLAVE_READ_WORD_FILTER_EN
#(
    parameter int FILT_LEN = 3
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1_r;
    logic sync2_r;
    logic lvl_s;
    logic dly_r;
    logic rise_r;
    logic fall_r;

    // Two-stage synchroniser, resets to the idle bus level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= BUS_IDLE;
            sync2_r <= BUS_IDLE;
        end else begin
            sync1_r <= line_i;
            sync2_r <= sync1_r;
        end
    end

`ifdef I2C_SLAVE_READ_WORD_FILTER_EN
    localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [CNT_W-1:0] filt_cnt_r;
    logic             filt_r;

    // Filtered level follows the input only after FILT_LEN equal samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt_r <= {CNT_W{1'b0}};
            filt_r     <= BUS_IDLE;
        end else if (sync2_r != filt_r) begin
            if (filt_cnt_r == CNT_W'(FILT_LEN - 1)) begin
                filt_r     <= sync2_r;
                filt_cnt_r <= {CNT_W{1'b0}};
            end else begin
                filt_cnt_r <= filt_cnt_r + CNT_W'(1);
            end
        end else begin
            filt_cnt_r <= {CNT_W{1'b0}};
        end
    end

    assign lvl_s = filt_r;
`else
    assign lvl_s = sync2_r;
`endif

    // Delay register plus registered edge pulses; dly_r doubles as the
    // level output so level and edges describe the same sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_r  <= BUS_IDLE;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            dly_r  <= lvl_s;
            rise_r <= lvl_s & ~dly_r;
            fall_r <= ~lvl_s & dly_r;
        end
    end

    assign level = dly_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/i2c_slave_read_word.sv
// I2C slave receive engine: shifts in 1..DATA_W bits MSB first on SCL
// rising edges, reports each bit serially and the word in parallel, and
// flags START/STOP conditions and mid-word aborts.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   rd_en, rd_len       : start request (level) and bit count (0 => DATA_W)
//   rd_ld, data_o       : per-bit strobe and bit value
//   rd_data, rd_finish  : right-aligned word and completion/abort strobe
//   busy                : transfer in progress
//   get_start, get_stop : bus condition strobes (active in every state)
//   bus_err             : abort indication, coincident with rd_finish
//   scl_i, sda_i        : pad inputs
// Optional feature macro: I2C_SLAVE_READ_WORD_FILTER_EN.
module i2c_slave_read_word
    import i2c_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int LEN_W    = 5,
    parameter int FILT_LEN = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [LEN_W-1:0]  rd_len,
    output logic              rd_ld,
    output logic              data_o,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_finish,
    output logic              busy,
    output logic              get_start,
    output logic              get_stop,
    output logic              bus_err,
    input  logic              scl_i,
    input  logic              sda_i
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

`ifdef I2C_SLAVE_READ_WORD_FILTER_EN
    i2c_line_cond #(.FILT_LEN(FILT_LEN)) u_scl_cond (
`else
    i2c_line_cond u_scl_cond (
`endif
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (scl_i),
        .level  (scl_lvl),
        .rise   (scl_rise),
        .fall   (scl_fall)
    );

`ifdef I2C_SLAVE_READ_WORD_FILTER_EN
    i2c_line_cond #(.FILT_LEN(FILT_LEN)) u_sda_cond (
`else
    i2c_line_cond u_sda_cond (
`endif
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (sda_i),
        .level  (sda_lvl),
        .rise   (sda_rise),
        .fall   (sda_fall)
    );

    // An SCL edge in the same sample masks any SDA edge (SCL wins).
    logic start_s;
    logic stop_s;
    assign start_s = sda_fall & scl_lvl & ~scl_rise & ~scl_fall;
    assign stop_s  = sda_rise & scl_lvl & ~scl_rise & ~scl_fall;

    state_t            state_r, next_state_s;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  count_r;
    logic [DATA_W-1:0] shift_r;

    logic              rd_ld_r, data_o_r, rd_finish_r, busy_r;
    logic              get_start_r, get_stop_r, bus_err_r;
    logic [DATA_W-1:0] rd_data_r;

    logic              rd_ld_s, data_o_s, rd_finish_s, busy_s;
    logic              bus_err_s;
    logic [DATA_W-1:0] rd_data_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rd_en) begin
                    next_state_s = ST_WAIT_HI;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT_HI: begin
                if (scl_rise) begin
                    next_state_s = ST_HOLD_HI;
                end else begin
                    next_state_s = ST_WAIT_HI;
                end
            end
            ST_HOLD_HI: begin
                if (scl_fall) begin
                    if (count_r == len_r) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_WAIT_HI;
                    end
                end else if (start_s || stop_s) begin
                    next_state_s = ST_ABORT;
                end else begin
                    next_state_s = ST_HOLD_HI;
                end
            end
            ST_DONE:  next_state_s = ST_IDLE;
            ST_ABORT: next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // FSM output decode; values are registered so the strobes land in the
    // cycle the FSM enters DONE/ABORT.
    always_comb begin
        rd_ld_s     = 1'b0;
        data_o_s    = 1'b0;
        rd_finish_s = 1'b0;
        bus_err_s   = 1'b0;
        busy_s      = 1'b0;
        rd_data_s   = rd_data_r;
        if ((state_r == ST_WAIT_HI) && scl_rise) begin
            rd_ld_s  = 1'b1;
            data_o_s = sda_lvl;
        end else begin
            rd_ld_s  = 1'b0;
            data_o_s = 1'b0;
        end
        if ((next_state_s == ST_DONE) || (next_state_s == ST_ABORT)) begin
            rd_finish_s = 1'b1;
            rd_data_s   = shift_r;
        end else begin
            rd_finish_s = 1'b0;
        end
        if (next_state_s == ST_ABORT) begin
            bus_err_s = 1'b1;
        end else begin
            bus_err_s = 1'b0;
        end
        if ((next_state_s == ST_WAIT_HI) || (next_state_s == ST_HOLD_HI)) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
    end

    // Transfer datapath: length latch, bit counter, shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_r   <= {LEN_W{1'b0}};
            count_r <= {LEN_W{1'b0}};
            shift_r <= {DATA_W{1'b0}};
        end else if ((state_r == ST_IDLE) && rd_en) begin
            len_r   <= LEN_W'(len_clamp(32'(rd_len), DATA_W));
            count_r <= {LEN_W{1'b0}};
            shift_r <= {DATA_W{1'b0}};
        end else if ((state_r == ST_WAIT_HI) && scl_rise) begin
            // Cleared at start, so shifting in from the LSB keeps a short
            // or aborted word right-aligned.
            shift_r <= {shift_r[DATA_W-2:0], sda_lvl};
            if (count_r < len_r) begin
                count_r <= count_r + LEN_W'(1);
            end else begin
                count_r <= count_r;
            end
        end else begin
            len_r   <= len_r;
            count_r <= count_r;
            shift_r <= shift_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ld_r     <= 1'b0;
            data_o_r    <= 1'b0;
            rd_finish_r <= 1'b0;
            busy_r      <= 1'b0;
            get_start_r <= 1'b0;
            get_stop_r  <= 1'b0;
            bus_err_r   <= 1'b0;
            rd_data_r   <= {DATA_W{1'b0}};
        end else begin
            rd_ld_r     <= rd_ld_s;
            data_o_r    <= data_o_s;
            rd_finish_r <= rd_finish_s;
            busy_r      <= busy_s;
            get_start_r <= start_s;
            get_stop_r  <= stop_s;
            bus_err_r   <= bus_err_s;
            rd_data_r   <= rd_data_s;
        end
    end

    assign rd_ld     = rd_ld_r;
    assign data_o    = data_o_r;
    assign rd_finish = rd_finish_r;
    assign busy      = busy_r;
    assign get_start = get_start_r;
    assign get_stop  = get_stop_r;
    assign bus_err   = bus_err_r;
    assign rd_data   = rd_data_r;

endmodule

// File: doc/i2c_slave_read_word.md
Name: i2c_slave_read_word

Overview:
- Parametrised successor to the single-bit/single-byte I2C slave receive engine.
- Receives a run-time selectable number of bits, 1..DATA_W, MSB first from SDA, sampling on SCL rising edges.
- Presents each bit serially (rd_ld/data_o) and the assembled word in parallel.
- Sits between the I2C pads and the slave controller FSM. Also reports START, STOP and mid-word bus errors.

Parameters:
- DATA_W, 16, maximum bits per transfer (>=8).
- LEN_W, 5, width of rd_len; must hold DATA_W.
- FILT_LEN, 3, glitch-filter depth in clk cycles (used only with the filter macro).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rd_en  in  1  level; start/continue a transfer; sampled in IDLE
- rd_len  in  LEN_W  bits to receive; latched when the transfer starts; 0 or >DATA_W is treated as DATA_W
- rd_ld  out  1  one-cycle pulse per received bit
- data_o  out  1  received bit, valid with rd_ld
- rd_data  out  DATA_W  parallel word, right-aligned, valid with rd_finish
- rd_finish  out  1  one-cycle pulse on completion or abort
- busy  out  1  high from transfer start until rd_finish
- get_start  out  1  pulse: SDA fall while SCL high
- get_stop  out  1  pulse: SDA rise while SCL high
- bus_err  out  1  pulse coincident with rd_finish when the transfer aborted
- scl_i  in  1  SCL from pad
- sda_i  in  1  SDA from pad

Behaviour:
- Reset values: all outputs 0, rd_data 0. Synchroniser flops reset to 1 (idle bus). FSM goes to IDLE.
- Input path: scl_i/sda_i pass through a 2-flop synchroniser, then one delay register for edge detection. Bus-event latency is 3 clk from pin to detection.
- START/STOP detection runs in every state, including IDLE: get_start/get_stop pulse 1 cycle.
- If SCL and SDA change in the same sample, SCL is given priority: no START/STOP is flagged.
- FSM states:
  - IDLE: on rd_en=1, latch len (clamped) and clear the bit counter and shift register. Go to WAIT_HI; busy=1.
  - WAIT_HI: wait for SCL rising edge. On the edge, shift in SDA, pulse rd_ld with data_o=SDA, increment the count, go to HOLD_HI.
  - HOLD_HI: SCL high. SDA fall → get_start plus abort; SDA rise → get_stop plus abort. SCL falling edge → go to DONE if count==len, else WAIT_HI.
  - DONE: pulse rd_finish, drive rd_data, clear busy. Go to IDLE.
  - ABORT: pulse rd_finish and bus_err in the same cycle, with rd_data = bits received so far, right-aligned. Go to IDLE.
- rd_finish timing: it pulses the cycle after the last SCL fall is detected, i.e. 4 clk after the pin falls.
- rd_en is a level: deassertion mid-transfer has no effect. A transfer is only started from IDLE. rd_en still high after DONE starts a new transfer on the next cycle.
- SDA change while SCL low is legal data setup and is ignored.
- Counter wraps are impossible: count saturates at len.
- Reset asserted mid-transfer returns to IDLE immediately with no rd_finish.

Optional Feature:
- Macro: I2C_SLAVE_READ_WORD_FILTER_EN.
- Defined: after the synchroniser, each line passes a FILT_LEN-deep majority/stability filter. The filtered level changes only after FILT_LEN consecutive equal samples. Pulses shorter than FILT_LEN clk are rejected, and pin-to-detection latency becomes 3+FILT_LEN clk.
- Undefined: no filter, 3 clk latency, and FILT_LEN is unused.

Decomposition:
- Shared package i2c_pkg: FSM state encoding, an LEN_CLAMP function, and bus-idle constant (1'b1).
- One natural sub-module: i2c_line_cond, which does the synchroniser, optional filter, rise/fall detection, per line. It is instantiated twice, for SCL and SDA.

Test Plan:
- rd_len=1, SDA=1 on one SCL pulse → one rd_ld with data_o=1; rd_finish; rd_data=16'h0001; bus_err=0.
- rd_len=8, byte 8'hA5 → 8 rd_ld pulses 1,0,1,0,0,1,0,1; rd_data=16'h00A5; rd_finish one cycle.
- rd_len=16, word 16'hC33C → rd_data=16'hC33C. rd_len=0 behaves identically to 16.
- rd_len=8, toggle SDA 1→0 while SCL high after bit 3 (data 1,0,1) → get_start pulse; rd_finish+bus_err same cycle; rd_data=16'h0005.
- Same with 0→1 toggle after bit 5 → get_stop, bus_err, 5 bits in rd_data. Repeat with the toggle after each of bits 1..8.
- Filter build, FILT_LEN=3: a 2-clk SCL glitch high mid-low-phase → no rd_ld. A 3-clk-stable pulse → rd_ld. Reset mid-word → outputs 0, no rd_finish.
